// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the fetch PC, requests the I-cache, predicts JAL and
// backward branches statically, and buffers fetched instructions in an in-order queue.
module ins_fetch #(
  parameter int          QUE_SIZE = 8,
  parameter logic [31:0] RST_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        ic_en_o,
  output logic [31:0] ic_pc_o,
  input  logic        ic_en_i,
  input  logic [31:0] ic_ins_i,
  input  logic        dec_rdy_i,
  output logic        dec_en_o,
  output logic [31:0] dec_ins_o,
  output logic [31:0] dec_pc_o,
  output logic        dec_pred_o,
  output logic [31:0] dec_pred_pc_o,
  input  logic        br_flag,
  input  logic [31:0] br_pc_i
);

  localparam int PTR_W = $clog2(QUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUE_SIZE);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;

  state_t state, state_nxt;

  logic [31:0]      pc;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [31:0] q_ins  [QUE_SIZE];
  logic [31:0] q_pc   [QUE_SIZE];
  logic [31:0] q_npc  [QUE_SIZE];
  logic        q_pred [QUE_SIZE];

  logic        push, pop;
  logic        is_c16;
  logic [31:0] j_imm, b_imm;
  logic [31:0] fetch_ins, fetch_npc;
  logic        fetch_pred;

  assign ic_pc_o  = pc;
  assign ic_en_o  = en && (state == RUN) && (count < CNT_FULL) && !br_flag;
  assign dec_en_o = (count != '0);
  assign push     = ic_en_o && ic_en_i;
  assign pop      = dec_en_o && dec_rdy_i && en && !br_flag;

  // Head fields are forced to zero while the queue is empty, so stale slots never leak out.
  assign dec_ins_o     = dec_en_o ? q_ins[head]  : '0;
  assign dec_pc_o      = dec_en_o ? q_pc[head]   : '0;
  assign dec_pred_o    = dec_en_o ? q_pred[head] : 1'b0;
  assign dec_pred_pc_o = dec_en_o ? q_npc[head]  : '0;

  always_comb begin
    is_c16     = (ic_ins_i[1:0] != 2'b11);
    j_imm      = {{12{ic_ins_i[31]}}, ic_ins_i[19:12], ic_ins_i[20], ic_ins_i[30:21], 1'b0};
    b_imm      = {{20{ic_ins_i[31]}}, ic_ins_i[7], ic_ins_i[30:25], ic_ins_i[11:8], 1'b0};
    fetch_ins  = ic_ins_i;
    fetch_pred = 1'b0;
    fetch_npc  = pc + 32'd4;
    if (is_c16) begin
      fetch_ins = {16'b0, ic_ins_i[15:0]};
      fetch_npc = pc + 32'd2;
    end else if (ic_ins_i[6:0] == OP_JAL) begin
      fetch_pred = 1'b1;
      fetch_npc  = pc + j_imm;
    end else if ((ic_ins_i[6:0] == OP_BRANCH) && ic_ins_i[31]) begin
      fetch_pred = 1'b1;
      fetch_npc  = pc + b_imm;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      if (br_flag) begin
        state_nxt = REDIR;
      end else if (state != RUN) begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect outranks the same cycle's hit and pop: the queue is emptied outright.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RST_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (br_flag) begin
        pc    <= br_pc_i;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc   <= fetch_npc;
          tail <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_ins[tail]  <= fetch_ins;
      q_pc[tail]   <= pc;
      q_npc[tail]  <= fetch_npc;
      q_pred[tail] <= fetch_pred;
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Randomized scoreboard bench for ins_fetch: the bench plays the I-cache from a lazily
// generated instruction memory and predicts every fetch and decoder handoff.
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ic_en_o;
  logic [31:0] ic_pc_o;
  logic        ic_en_i = 1'b0;
  logic [31:0] ic_ins_i = '0;
  logic        dec_rdy_i = 1'b0;
  logic        dec_en_o;
  logic [31:0] dec_ins_o;
  logic [31:0] dec_pc_o;
  logic        dec_pred_o;
  logic [31:0] dec_pred_pc_o;
  logic        br_flag = 1'b0;
  logic [31:0] br_pc_i = '0;

  always #5 clk = ~clk;

  ins_fetch #(.QUE_SIZE(8), .RST_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ic_en_o(ic_en_o), .ic_pc_o(ic_pc_o), .ic_en_i(ic_en_i), .ic_ins_i(ic_ins_i),
    .dec_rdy_i(dec_rdy_i), .dec_en_o(dec_en_o), .dec_ins_o(dec_ins_o),
    .dec_pc_o(dec_pc_o), .dec_pred_o(dec_pred_o), .dec_pred_pc_o(dec_pred_pc_o),
    .br_flag(br_flag), .br_pc_i(br_pc_i)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred;
  } entry_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] imem [logic [31:0]];
  entry_t      exp_q [$];
  logic [31:0] m_pc = 32'h0;
  bit          m_live = 1'b0;
  bit          popped_now = 1'b0;
  bit          was_reset = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_ins();
    logic [31:0] raw;
    int kind;
    raw  = $urandom;
    kind = $urandom_range(0, 9);
    if (kind <= 2) begin
      raw[1:0] = 2'($urandom_range(0, 2));
    end else if (kind == 3) begin
      raw[6:0] = 7'h6F;
    end else if (kind <= 5) begin
      raw[6:0] = 7'h63;
    end else if (kind == 6) begin
      raw[6:0] = 7'h67;
    end else begin
      raw[6:0] = (kind == 7) ? 7'h33 : 7'h13;
    end
    return raw;
  endfunction

  function automatic logic [31:0] ins_at(input logic [31:0] pc);
    if (!imem.exists(pc)) imem[pc] = gen_ins();
    return imem[pc];
  endfunction

  // Reference decode: offsets are summed from their bit fields as plain signed integers.
  function automatic entry_t predict(input logic [31:0] pc, input logic [31:0] raw);
    entry_t e;
    int imm;
    e.pc   = pc;
    e.ins  = raw;
    e.pred = 1'b0;
    e.npc  = pc + 32'd4;
    if (raw[1:0] != 2'b11) begin
      e.ins = raw & 32'h0000FFFF;
      e.npc = pc + 32'd2;
    end else if (raw[6:0] == 7'h6F) begin
      imm = raw[31] ? -(1 << 20) : 0;
      imm += int'(raw[19:12]) * 4096 + int'(raw[20]) * 2048 + int'(raw[30:21]) * 2;
      e.pred = 1'b1;
      e.npc  = pc + 32'(imm);
    end else if (raw[6:0] == 7'h63 && raw[31]) begin
      imm = -4096 + int'(raw[7]) * 2048 + int'(raw[30:25]) * 32 + int'(raw[11:8]) * 2;
      e.pred = 1'b1;
      e.npc  = pc + 32'(imm);
    end
    return e;
  endfunction

  // Monitor: consumes an expected entry whenever the DUT hands one to the decoder.
  always @(negedge clk) begin
    entry_t e;
    #1;
    popped_now = 1'b0;
    if (rst_n) begin
      checkOutput("dec_en_o", 32'(dec_en_o), 32'(exp_q.size() != 0));
      if (dec_en_o && dec_rdy_i && en && !br_flag) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pop_pc", dec_pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          popped_now = 1'b1;
          checkOutput("dec_pc_o", dec_pc_o, e.pc);
          checkOutput("dec_ins_o", dec_ins_o, e.ins);
          checkOutput("dec_pred_o", 32'(dec_pred_o), 32'(e.pred));
          checkOutput("dec_pred_pc_o", dec_pred_pc_o, e.npc);
        end
      end
    end
  end

  task automatic applyStimulus(input bit rst_val, input int p_en, input int p_hit,
                               input int p_rdy, input int p_br);
    int cnt_before;
    bit exp_ic;
    entry_t e;
    @(negedge clk);
    rst_n     = rst_val;
    en        = ($urandom_range(0, 99) < p_en);
    ic_en_i   = ($urandom_range(0, 99) < p_hit);
    dec_rdy_i = ($urandom_range(0, 99) < p_rdy);
    br_flag   = ($urandom_range(0, 99) < p_br);
    br_pc_i   = $urandom & 32'hFFFF_FFFE;
    ic_ins_i  = ins_at(m_pc);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      m_pc      = 32'h0;
      m_live    = 1'b0;
      was_reset = 1'b1;
    end else begin
      if (was_reset) begin
        checkOutput("rst_dec_ins_o", dec_ins_o, 32'h0);
        checkOutput("rst_dec_pc_o", dec_pc_o, 32'h0);
        checkOutput("rst_dec_pred_o", 32'(dec_pred_o), 32'h0);
        checkOutput("rst_dec_pred_pc_o", dec_pred_pc_o, 32'h0);
        was_reset = 1'b0;
      end
      cnt_before = exp_q.size() + int'(popped_now);
      exp_ic = en && m_live && (cnt_before < 8) && !br_flag;
      checkOutput("ic_en_o", 32'(ic_en_o), 32'(exp_ic));
      checkOutput("ic_pc_o", ic_pc_o, m_pc);
      if (en) begin
        if (br_flag) begin
          exp_q.delete();
          m_pc   = br_pc_i;
          m_live = 1'b0;
        end else begin
          if (exp_ic && ic_en_i) begin
            e = predict(m_pc, ic_ins_i);
            exp_q.push_back(e);
            m_pc = e.npc;
          end
          m_live = 1'b1;
        end
      end
    end
  endtask

  initial begin
    // Short straight-line code, a 16/32-bit mix, a JAL +0x20 and a backward branch -8.
    imem[32'h00] = 32'hABCD_4501;
    imem[32'h02] = 32'h0000_0013;
    imem[32'h06] = 32'h0000_0013;
    imem[32'h0A] = 32'h0000_0013;
    imem[32'h0E] = 32'h1234_0001;
    imem[32'h10] = 32'h0200_006F;
    imem[32'h30] = 32'h0000_0013;
    imem[32'h34] = 32'h0000_0013;
    imem[32'h38] = 32'h0000_0013;
    imem[32'h3C] = 32'h0000_0013;
    imem[32'h40] = 32'hFE00_0CE3;

    repeat (2) applyStimulus(1'b0, 100, 100, 100, 0);
    repeat (40) applyStimulus(1'b1, 100, 100, 100, 0);
    repeat (30) applyStimulus(1'b1, 100, 100, 0, 0);
    repeat (10) applyStimulus(1'b1, 100, 100, 100, 0);
    repeat (300) applyStimulus(1'b1, 80, 70, 60, 5);
    applyStimulus(1'b0, 100, 100, 100, 0);
    repeat (300) applyStimulus(1'b1, 50, 30, 80, 10);
    repeat (15) applyStimulus(1'b1, 100, 100, 0, 0);
    applyStimulus(1'b1, 100, 100, 100, 100);
    repeat (20) applyStimulus(1'b1, 100, 100, 100, 0);
    repeat (200) applyStimulus(1'b1, 90, 50, 50, 3);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage: owns the architectural fetch PC, drives the instruction cache, and buffers returned instructions in a small in-order queue for the decoder. It applies static next-PC prediction for JAL and backward conditional branches. On a branch redirect from the back end it flushes the queue and restarts fetch at the corrected PC. It sits between the instruction cache (downstream of it for data, upstream of it for requests) and the decoder.

## Interface
- QUE_SIZE, 8: instruction queue depth; power of two, ≥2.
- RST_PC, 32'h0: fetch PC after reset.

- clk  in  1  clock; one clock, all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  global ready; when low, all state holds.
- ic_en_o  out  1  fetch request to cache; cache samples it on the rising edge.
- ic_pc_o  out  32  fetch PC; halfword aligned; direct from PC register.
- ic_en_i  in  1  cache hit for ic_pc_o in the current cycle (combinational from cache).
- ic_ins_i  in  32  instruction bits at ic_pc_o; valid when ic_en_i=1.
- dec_rdy_i  in  1  decoder accepts the head entry this cycle.
- dec_en_o  out  1  queue non-empty (head valid).
- dec_ins_o  out  32  head instruction; 16-bit forms zero-extended.
- dec_pc_o  out  32  head PC.
- dec_pred_o  out  1  head was predicted taken.
- dec_pred_pc_o  out  32  PC fetch continued from after head.
- br_flag  in  1  mispredict/redirect from back end.
- br_pc_i  in  32  redirect target; valid when br_flag=1.

## Operation
- FSM states: IDLE, RUN, REDIR.
  - Reset → IDLE.
  - IDLE → RUN after one enabled cycle.
  - RUN → REDIR on br_flag.
  - REDIR → RUN after one enabled cycle, unless br_flag is high again (stays REDIR, reloads PC).
- ic_en_o = en && state==RUN && count<QUE_SIZE && !br_flag.
- Push: in RUN with ic_en_o=1 and ic_en_i=1, write {ic_pc_o, ins, pred, next_pc} at tail; PC ← next_pc.
- Miss (ic_en_i=0): PC and ic_en_o hold until a hit arrives.
- Length decode:
  - ic_ins_i[1:0]≠2'b11 → 16-bit; stored ins = {16'b0, ic_ins_i[15:0]}; next_pc = pc+2; pred=0.
  - Otherwise 32-bit.
- Prediction for 32-bit instructions:
  - Opcode 7'b1101111 (JAL): next_pc = pc + sext J-imm; pred=1.
  - Opcode 7'b1100011 (branch) with imm[12]=1 (backward): next_pc = pc + sext B-imm; pred=1.
  - Anything else, including forward branches and JALR: next_pc = pc+4; pred=0.
- All PC arithmetic is 32-bit modulo 2^32; no alignment checking.
- Pop: dec_en_o && dec_rdy_i && en advances head. Push and pop may occur in the same cycle.
- The full check uses count before the pop: a full queue does not accept a push even if it pops that cycle.
- Head/tail pointers are log2(QUE_SIZE) bits and wrap naturally.
- Count is log2(QUE_SIZE)+1 bits, range 0..QUE_SIZE.
- br_flag (when en) has priority over push and pop:
  - head, tail, count ← 0; PC ← br_pc_i; state ← REDIR.
  - That cycle's hit is discarded.
- en=0: no push, no pop, no state change; ic_en_o=0; dec_en_o reflects count but no pop occurs.

## Timing
- Reset values: ic_en_o=0, ic_pc_o=RST_PC, dec_en_o=0, dec_ins_o=0, dec_pc_o=0, dec_pred_o=0, dec_pred_pc_o=0, count=0, state=IDLE.
- Reset mid-operation discards queue contents and any outstanding miss. The cache must be reset in the same cycle.
- Hit latency: hit in cycle N → entry visible on dec_* in cycle N+1 (no bypass).
- Throughput on hits: one instruction per cycle.
- Redirect: br_flag in cycle N → ic_en_o=0 in N and N+1 (REDIR) → ic_en_o=1 with ic_pc_o=br_pc_i in cycle N+2. Queue is empty from N+1.
- Miss: ic_en_o stays high for every cycle until the hit; the cache's fill result is consumed as a hit in a later cycle.

## Test plan
- Sequential 32-bit stream, dec_rdy_i=1, all hits from RST_PC=0 → dec_pc_o = 0,4,8,… on consecutive cycles starting at cycle 3 after reset release; dec_pred_o=0.
- Compressed mix: ins at 0 is 16'h4501 (16-bit), at 2 is 32'h00000013 → dec_pc_o 0 then 2, dec_ins_o=32'h00004501 then 32'h00000013, next fetch at 6.
- JAL at 0x10 with imm +0x20 and a backward branch at 0x40 with offset −8 → ic_pc_o goes to 0x30, then 0x38; both entries have dec_pred_o=1 and the correct dec_pred_pc_o.
- Full queue: dec_rdy_i=0, QUE_SIZE=8 hits → count=8, ic_en_o=0. Raise dec_rdy_i → one pop, then fetch resumes the next cycle; no entry lost or duplicated.
- Redirect with full queue, simultaneous hit and pop: br_flag=1, br_pc_i=0x100 → dec_en_o=0 next cycle; ic_en_o=1 with ic_pc_o=0x100 two cycles later; the discarded hit never appears.
- Miss and en: ic_en_i low for 5 cycles with en toggling → PC holds, no push; entry pushed in the cycle after ic_en_i rises with en=1.
